// File: rtl/command_manager_if.sv
`default_nettype none
// ============================================================================
// command_manager_if : UART-byte / register-file bus of the command manager
// Revision: 1.0
// ============================================================================
interface command_manager_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic [DATA_W-1:0] i_read_reg;
  logic [DATA_W-1:0] i_rx_data;
  logic              i_rx_data_valid;
  logic [DATA_W-1:0] o_write_reg;
  logic [DATA_W-1:0] o_tx_data;
  logic              o_tx_data_valid;
  logic [ADDR_W-1:0] o_rwaddr;
  logic              o_rd_req;
  logic              o_wr_req;

  // master: the command manager itself
  modport master (
    input  i_read_reg, i_rx_data, i_rx_data_valid,
    output o_write_reg, o_tx_data, o_tx_data_valid, o_rwaddr, o_rd_req, o_wr_req
  );

  // slave: UART and register file around it
  modport slave (
    output i_read_reg, i_rx_data, i_rx_data_valid,
    input  o_write_reg, o_tx_data, o_tx_data_valid, o_rwaddr, o_rd_req, o_wr_req
  );
endinterface
`default_nettype wire

// File: rtl/command_manager.sv
`default_nettype none
// ============================================================================
// command_manager : decodes UART command bytes into register reads/writes
// Revision: 1.0
// ============================================================================
module command_manager #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  wire logic          i_clk,
  input  wire logic          i_rst,
  command_manager_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RD_REQ    = 3'd1,
    S_RD_SEND   = 3'd2,
    S_WAIT_DATA = 3'd3,
    S_WR_REQ    = 3'd4
  } state_t;

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_addr, w_addr_next;
  logic [ADDR_W-1:0] r_rwaddr, w_rwaddr_next;
  logic [DATA_W-1:0] r_write_reg, w_write_reg_next;
  logic [DATA_W-1:0] r_tx_data, w_tx_data_next;
  logic              r_tx_valid, w_tx_valid_next;
  logic              r_rd_req, w_rd_req_next;
  logic              r_wr_req, w_wr_req_next;

  // Command byte: {zero padding, addr, rw}; any non-zero padding bit is invalid
  logic              w_cmd_ok;
  logic [ADDR_W-1:0] w_cmd_addr;
  logic              w_cmd_rw;

  assign w_cmd_ok   = (bus.i_rx_data[DATA_W-1:ADDR_W+1] == '0);
  assign w_cmd_addr = bus.i_rx_data[ADDR_W:1];
  assign w_cmd_rw   = bus.i_rx_data[0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_rwaddr    <= '0;
      r_write_reg <= '0;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_rd_req    <= 1'b0;
      r_wr_req    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_addr      <= w_addr_next;
      r_rwaddr    <= w_rwaddr_next;
      r_write_reg <= w_write_reg_next;
      r_tx_data   <= w_tx_data_next;
      r_tx_valid  <= w_tx_valid_next;
      r_rd_req    <= w_rd_req_next;
      r_wr_req    <= w_wr_req_next;
    end
  end

  // Strobes are computed one state ahead so every output leaves a flop
  always_comb begin
    w_state_next     = r_state;
    w_addr_next      = r_addr;
    w_rwaddr_next    = r_rwaddr;
    w_write_reg_next = r_write_reg;
    w_tx_data_next   = r_tx_data;
    w_tx_valid_next  = 1'b0;
    w_rd_req_next    = 1'b0;
    w_wr_req_next    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.i_rx_data_valid && w_cmd_ok) begin
          w_addr_next = w_cmd_addr;
          if (w_cmd_rw) begin
            w_state_next = S_WAIT_DATA;
          end else begin
            w_state_next  = S_RD_REQ;
            w_rd_req_next = 1'b1;
            w_rwaddr_next = w_cmd_addr;
          end
        end
      end
      S_RD_REQ: begin
        // read data is valid while o_rwaddr presents the read address
        w_tx_data_next  = bus.i_read_reg;
        w_tx_valid_next = 1'b1;
        w_state_next    = S_RD_SEND;
      end
      S_RD_SEND: begin
        w_state_next = S_IDLE;
      end
      S_WAIT_DATA: begin
        if (bus.i_rx_data_valid) begin
          w_write_reg_next = bus.i_rx_data;
          w_wr_req_next    = 1'b1;
          w_rwaddr_next    = r_addr;
          w_state_next     = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign bus.o_write_reg     = r_write_reg;
  assign bus.o_tx_data       = r_tx_data;
  assign bus.o_tx_data_valid = r_tx_valid;
  assign bus.o_rwaddr        = r_rwaddr;
  assign bus.o_rd_req        = r_rd_req;
  assign bus.o_wr_req        = r_wr_req;

endmodule
`default_nettype wire

// File: tb/tb_command_manager.sv
`default_nettype none
// ============================================================================
// tb_command_manager : directed checks of command decode, read and write paths
// Revision: 1.0
// ============================================================================
module tb_command_manager;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  command_manager_if #(.DATA_W(8), .ADDR_W(3)) bus ();

  command_manager #(.DATA_W(8), .ADDR_W(3)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // strobes packed as {rd_req, wr_req, tx_data_valid}
  task automatic chk_strb(input string tag, input logic [2:0] exp);
    chk(tag, {29'd0, bus.o_rd_req, bus.o_wr_req, bus.o_tx_data_valid}, {29'd0, exp});
  endtask

  task automatic send(input logic [7:0] b);
    bus.i_rx_data       = b;
    bus.i_rx_data_valid = 1'b1;
    step();
    bus.i_rx_data_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst                 = 1'b1;
    bus.i_read_reg      = 8'h00;
    bus.i_rx_data       = 8'h00;
    bus.i_rx_data_valid = 1'b0;
    step();
    step();
    chk_strb("reset_strobes", 3'b000);
    chk("reset_rwaddr",    {29'd0, bus.o_rwaddr},    32'h0);
    chk("reset_write_reg", {24'd0, bus.o_write_reg}, 32'h0);
    chk("reset_tx_data",   {24'd0, bus.o_tx_data},   32'h0);
    rst = 1'b0;
    step();
    chk_strb("idle_quiet", 3'b000);

    // read addr 0
    bus.i_read_reg = 8'h08;
    send(8'h00);
    chk_strb("rd0_req", 3'b100);
    chk("rd0_addr", {29'd0, bus.o_rwaddr}, 32'h0);
    step();
    chk_strb("rd0_send", 3'b001);
    chk("rd0_data", {24'd0, bus.o_tx_data}, 32'h08);
    step();
    chk_strb("rd0_done", 3'b000);
    chk("rd0_hold", {24'd0, bus.o_tx_data}, 32'h08);

    // write addr 1, data two cycles later
    send(8'h03);
    chk_strb("wr1_wait_a", 3'b000);
    step();
    chk_strb("wr1_wait_b", 3'b000);
    send(8'hAA);
    chk_strb("wr1_req", 3'b010);
    chk("wr1_addr", {29'd0, bus.o_rwaddr}, 32'h1);
    chk("wr1_data", {24'd0, bus.o_write_reg}, 32'hAA);
    step();
    chk_strb("wr1_done", 3'b000);
    chk("wr1_hold", {24'd0, bus.o_write_reg}, 32'hAA);

    // invalid command, then read addr 7
    send(8'h13);
    chk_strb("inv_a", 3'b000);
    step();
    chk_strb("inv_b", 3'b000);
    bus.i_read_reg = 8'h77;
    send(8'h0E);
    chk_strb("rd7_req", 3'b100);
    chk("rd7_addr", {29'd0, bus.o_rwaddr}, 32'h7);
    step();
    chk_strb("rd7_send", 3'b001);
    chk("rd7_data", {24'd0, bus.o_tx_data}, 32'h77);
    step();

    // write addr 5 with data that looks like a read command
    send(8'h0B);
    chk_strb("wr5_wait", 3'b000);
    send(8'h01);
    chk_strb("wr5_req", 3'b010);
    chk("wr5_addr", {29'd0, bus.o_rwaddr}, 32'h5);
    chk("wr5_data", {24'd0, bus.o_write_reg}, 32'h01);
    step();
    chk_strb("wr5_done", 3'b000);
    step();
    chk_strb("wr5_no_read", 3'b000);

    // reset while waiting for write data
    send(8'h0D);
    step();
    rst = 1'b1;
    #1;
    chk_strb("rst_mid_strobes", 3'b000);
    chk("rst_mid_rwaddr",    {29'd0, bus.o_rwaddr},    32'h0);
    chk("rst_mid_write_reg", {24'd0, bus.o_write_reg}, 32'h0);
    chk("rst_mid_tx_data",   {24'd0, bus.o_tx_data},   32'h0);
    step();
    rst = 1'b0;
    step();
    send(8'h55);
    chk_strb("rst_55_a", 3'b000);
    step();
    chk_strb("rst_55_b", 3'b000);
    step();
    chk_strb("rst_55_c", 3'b000);

    // back-to-back reads; bytes arriving during the read are dropped
    bus.i_read_reg = 8'h22;
    send(8'h04);
    chk_strb("rd2_req", 3'b100);
    chk("rd2_addr", {29'd0, bus.o_rwaddr}, 32'h2);
    bus.i_rx_data       = 8'h03;
    bus.i_rx_data_valid = 1'b1;
    step();
    chk_strb("rd2_send", 3'b001);
    chk("rd2_data", {24'd0, bus.o_tx_data}, 32'h22);
    step();
    bus.i_rx_data_valid = 1'b0;
    chk_strb("rd2_done", 3'b000);
    bus.i_read_reg = 8'h44;
    send(8'h08);
    chk_strb("rd4_req", 3'b100);
    chk("rd4_addr", {29'd0, bus.o_rwaddr}, 32'h4);
    step();
    chk_strb("rd4_send", 3'b001);
    chk("rd4_data", {24'd0, bus.o_tx_data}, 32'h44);
    step();
    chk_strb("rd4_done", 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/command_manager.md
COMMAND_MANAGER -- requirements
Module: command_manager

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the width of register and UART data bytes.
REQ-002 Parameter ADDR_W, default 3, SHALL set the width of the register address.
REQ-003 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 i_read_reg  input  DATA_W  SHALL carry the register value returned for the address on o_rwaddr.
REQ-006 i_rx_data  input  DATA_W  SHALL carry the received UART byte.
REQ-007 i_rx_data_valid  input  1  SHALL be a one-cycle strobe qualifying i_rx_data.
REQ-008 o_write_reg  output  DATA_W  SHALL carry the data byte to write to the register file.
REQ-009 o_tx_data  output  DATA_W  SHALL carry the byte to transmit over UART.
REQ-010 o_tx_data_valid  output  1  SHALL be a one-cycle strobe qualifying o_tx_data.
REQ-011 o_rwaddr  output  ADDR_W  SHALL carry the register address for read or write.
REQ-012 o_rd_req  output  1  SHALL be a one-cycle register read request.
REQ-013 o_wr_req  output  1  SHALL be a one-cycle register write request.

Function
REQ-014 Command byte format SHALL be {4'b0000, addr[2:0], rw}; rw=0 means read, rw=1 means write.
REQ-015 FSM states SHALL be IDLE, RD_REQ, RD_SEND, WAIT_DATA, WR_REQ.
REQ-016 In IDLE, a byte is accepted only on a cycle with i_rx_data_valid=1.
- Bits [7:4] = 0 and rw=0: latch addr, go to RD_REQ.
- Bits [7:4] = 0 and rw=1: latch addr, go to WAIT_DATA.
- Bits [7:4] non-zero: discard the byte, stay in IDLE, no outputs.
REQ-017 RD_REQ SHALL last one cycle (N+1 after command sampled at edge N).
- o_rd_req=1, o_rwaddr=addr.
- At the end of this cycle, i_read_reg is captured into o_tx_data.
- Next state RD_SEND.
REQ-018 RD_SEND SHALL last one cycle (N+2): o_tx_data_valid=1, o_tx_data=captured value; then IDLE.
REQ-019 WAIT_DATA SHALL wait indefinitely (no timeout) for the next i_rx_data_valid.
- That byte is data, unconditionally, regardless of its value.
- It is latched into o_write_reg; next state WR_REQ.
REQ-020 WR_REQ SHALL last one cycle (M+1 after data sampled at edge M): o_wr_req=1, o_rwaddr=addr, o_write_reg=data; then IDLE.
REQ-021 i_rx_data_valid in RD_REQ, RD_SEND or WR_REQ SHALL be ignored (byte dropped).
REQ-022 o_rd_req, o_wr_req and o_tx_data_valid SHALL be mutually exclusive and each high for exactly one cycle per command.
REQ-023 o_rwaddr, o_write_reg and o_tx_data SHALL hold their last values between requests.
REQ-024 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-025 Read-to-response latency SHALL be 2 cycles from the command strobe edge to o_tx_data_valid.
REQ-026 Write latency SHALL be 1 cycle from the data strobe edge to o_wr_req.

Reset
REQ-027 While i_rst=1, the FSM SHALL be in IDLE, with no pending command.
REQ-028 While i_rst=1, all outputs SHALL be 0: o_write_reg, o_tx_data, o_rwaddr, o_tx_data_valid, o_rd_req, o_wr_req.
REQ-029 Reset asserted mid-command (any state) SHALL abort the command with no further strobes after release.

Verification
REQ-030 Read: i_read_reg=8'h08, command 8'h00 (addr 0, read) strobed -> o_rd_req=1, o_rwaddr=0 next cycle; o_tx_data_valid=1, o_tx_data=8'h08 the cycle after.
REQ-031 Write: command 8'h03 (addr 1, write), then data 8'hAA two cycles later -> o_wr_req=1, o_rwaddr=1, o_write_reg=8'hAA one cycle after the data strobe; no o_rd_req.
REQ-032 Invalid command 8'h13 -> no strobes; a following valid read command 8'h0E (addr 7) -> o_rd_req with o_rwaddr=7.
REQ-033 Write of data 8'h01 after command 8'h0B (addr 5) -> data is not decoded as a command; o_wr_req, o_rwaddr=5, o_write_reg=8'h01.
REQ-034 i_rst=1 asserted while in WAIT_DATA, then released, then byte 8'h55 -> treated as a command (invalid, upper nibble non-zero), so no o_wr_req.
REQ-035 Back-to-back reads at addr 2 then addr 4 -> two separate o_tx_data_valid pulses with matching i_read_reg values.
